// File: rtl/mux_2to1_pkg.sv
// Shared constants and select encodings for the de Bruijn routing word mux.
package mux_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int DEFAULT_CNT_W = 8;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

   // A sampled select differs from its previous sampled value.
   function automatic logic sel_changed(input logic cur, input logic prev);
      return cur ^ prev;
   endfunction

endpackage

// File: rtl/mux_2to1_sel_counter.sv
// Registers the select and counts its sampled value changes, saturating at all-ones.
module mux_sel_counter
   import mux_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   output logic             sel_q,
   output logic [CNT_W-1:0] toggle_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   logic             sel_r;
   logic [CNT_W-1:0] cnt_r;
   logic             toggle_s;
   logic [CNT_W-1:0] cnt_nxt_s;

   // Next count: advance on a sampled change unless already saturated.
   always_comb begin
      toggle_s  = 1'b0;
      cnt_nxt_s = cnt_r;
      toggle_s  = sel_changed(sel, sel_r);
      if (toggle_s && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Select history and counter state; reset forces the history to SEL_A.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_r <= SEL_A;
         cnt_r <= CNT_ZERO;
      end else begin
         sel_r <= sel;
         cnt_r <= cnt_nxt_s;
      end
   end

   assign sel_q      = sel_r;
   assign toggle_cnt = cnt_r;

endmodule

// File: rtl/mux_2to1.sv
// Two-input word mux with a combinational output, a registered copy and select-change monitoring.
module mux_2to1
   import mux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             sel_q,
   output logic [CNT_W-1:0] toggle_cnt
);

   logic [WIDTH-1:0] out_r;

   // Continuous ternary so an unknown select merges a and b bitwise in simulation.
   assign out = sel ? b : a;

   // Pipelined copy of the selected word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_r <= {WIDTH{1'b0}};
      end else begin
         out_r <= out;
      end
   end

   assign out_q = out_r;

   mux_sel_counter #(
      .CNT_W (CNT_W)
   ) u_sel_counter (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .sel_q      (sel_q),
      .toggle_cnt (toggle_cnt)
   );

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor pops and compares them.
module tb_mux_2to1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a, b, out, out_q, cnt;
   logic       sel, sel_q;
   logic       a2, b2, sel2, out2, out_q2, sel_q2;
   logic [1:0] cnt2;

   always #5 clk = ~clk;

   mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
      .out(out), .out_q(out_q), .sel_q(sel_q), .toggle_cnt(cnt)
   );

   mux_2to1 #(.WIDTH(1), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .a(a2), .b(b2), .sel(sel2),
      .out(out2), .out_q(out_q2), .sel_q(sel_q2), .toggle_cnt(cnt2)
   );

   typedef struct {
      int         sig;
      logic [7:0] exp;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] probe(input int sig);
      case (sig)
         0:       return out;
         1:       return out_q;
         2:       return {7'b0, sel_q};
         3:       return cnt;
         4:       return {6'b0, cnt2};
         5:       return {7'b0, sel_q2};
         default: return 8'hxx;
      endcase
   endfunction

   task automatic expect_v(input int sig, input logic [7:0] v, input string n);
      exp_t e;
      e.sig  = sig;
      e.exp  = v;
      e.name = n;
      sb_q.push_back(e);
   endtask

   task automatic sample();
      -> sample_ev;
      #1;
   endtask

   // Monitor: drain the scoreboard each time the stimulus marks a sample point.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (probe(e.sig) !== e.exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h at %0t", e.name, probe(e.sig), e.exp, $time);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   logic       reg_sel [3]  = '{1'b0, 1'b1, 1'b0};
   logic [7:0] reg_outq [3] = '{8'h3C, 8'hA5, 8'h3C};
   logic [7:0] reg_cnt [3]  = '{8'd0, 8'd1, 8'd2};

   logic       tog_sel [6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] tog_cnt [6]  = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3};
   logic [7:0] tog_outq [6] = '{8'h3C, 8'hA5, 8'hA5, 8'h3C, 8'hA5, 8'hA5};
   logic       sat_sel [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [7:0] sat_cnt [6]  = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};

   initial begin
      rst = 1'b1; a = 8'h00; b = 8'h00; sel = 1'b0;
      a2 = 1'b0; b2 = 1'b0; sel2 = 1'b0;

      // Combinational select, registers held in reset.
      #10;
      expect_v(0, 8'h00, "comb_a0_b0_s0");
      expect_v(1, 8'h00, "rst_out_q");
      expect_v(2, 8'h00, "rst_sel_q");
      expect_v(3, 8'h00, "rst_cnt");
      expect_v(4, 8'h00, "rst_cnt2");
      sample();
      #10 b = 8'h01;
      expect_v(0, 8'h00, "comb_a0_b1_s0");
      sample();
      #10 sel = 1'b1;
      expect_v(0, 8'h01, "comb_a0_b1_s1");
      sample();

      // Registered path: out_q trails out by one edge.
      @(negedge clk);
      a = 8'h3C; b = 8'hA5; sel = 1'b0; rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sel = reg_sel[i];
         #1;
         expect_v(0, reg_sel[i] ? 8'hA5 : 8'h3C, "reg_out_comb");
         sample();
         @(posedge clk); #1;
         expect_v(1, reg_outq[i], "reg_out_q");
         expect_v(2, {7'b0, reg_sel[i]}, "reg_sel_q");
         expect_v(3, reg_cnt[i], "reg_cnt");
         sample();
      end

      // Mid-cycle asynchronous reset with a nonzero counter.
      #2 rst = 1'b1;
      #1;
      expect_v(1, 8'h00, "midrst_out_q");
      expect_v(2, 8'h00, "midrst_sel_q");
      expect_v(3, 8'h00, "midrst_cnt");
      expect_v(0, 8'h3C, "midrst_out_a");
      sample();
      sel = 1'b1;
      #1;
      expect_v(0, 8'hA5, "midrst_out_b");
      sample();

      // Toggle counting on the wide instance, saturation on the narrow one.
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sel  = tog_sel[i];
         sel2 = sat_sel[i];
         @(posedge clk); #1;
         expect_v(3, tog_cnt[i], "tog_cnt");
         expect_v(1, tog_outq[i], "tog_out_q");
         expect_v(4, sat_cnt[i], "sat_cnt2");
         expect_v(5, {7'b0, sat_sel[i]}, "sat_sel_q2");
         sample();
      end

      // Glitches between edges: net-zero change is not counted, net change counts once.
      sel = 1'b0; #1 sel = 1'b1;
      @(posedge clk); #1;
      expect_v(3, 8'd3, "glitch_zero_cnt");
      expect_v(4, 8'd3, "sat_hold_cnt2");
      sample();
      sel = 1'b0; #1 sel = 1'b1; #1 sel = 1'b0;
      @(posedge clk); #1;
      expect_v(3, 8'd4, "glitch_net_cnt");
      expect_v(2, 8'h00, "glitch_sel_q");
      sample();

      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_2to1.md
# mux_2to1

Two-input word multiplexer for the de Bruijn routing datapath: selects input `a` or `b` onto `out` under control of `sel`. The selected word is available combinationally for same-cycle routing and as a registered copy for pipelined stages. A saturating counter of select transitions supports link-usage monitoring.

## Interface
Parameters:
- `WIDTH`, 1, data width of `a`, `b`, `out`, `out_q`
- `CNT_W`, 8, width of `toggle_cnt`

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous active-high reset
- `a`  in  WIDTH  data input selected when `sel`=0
- `b`  in  WIDTH  data input selected when `sel`=1
- `sel`  in  1  select: 0 → `a`, 1 → `b`
- `out`  out  WIDTH  combinational mux output
- `out_q`  out  WIDTH  registered copy of `out`
- `sel_q`  out  1  registered copy of `sel`
- `toggle_cnt`  out  CNT_W  saturating count of `sel` value changes

## Operation
- `out` = `sel` ? `b` : `a`, purely combinational, with no dependence on `clk` or `rst`.
- `sel` is treated as a strict 2-state select. If `sel` is X/Z in simulation, `out` follows the standard ternary merge. No special handling is applied.
- `out_q` loads `out` on every rising `clk` edge.
- `sel_q` loads `sel` on every rising `clk` edge.
- `toggle_cnt` increments by 1 on a rising edge when `sel` ≠ `sel_q`, meaning `sel` changed since the previous sampled cycle.
- `toggle_cnt` saturates at 2^CNT_W−1 and never wraps. It is cleared only by `rst`.
- The first sampled cycle after reset compares against `sel_q`=0. A `sel`=1 at that edge counts as one toggle.
- There are no state machines and no handshakes. The block is always ready.

## Timing
- `out`: zero-cycle latency, valid within the same delta as `a`/`b`/`sel`, and unaffected by reset.
- `out_q`, `sel_q`: 1-cycle latency.
- `toggle_cnt`: updates 1 cycle after the `sel` change is sampled.
- Reset values while `rst`=1: `out_q`=0, `sel_q`=0, `toggle_cnt`=0.
- Assertion of `rst` takes effect immediately, without a clock edge.
- After deassertion of `rst`, the first update occurs at the next rising edge.
- Reset asserted mid-operation: registers clear immediately, `out` continues to track its inputs, and the counter restarts from 0.
- Multiple `sel` changes between two clock edges count as at most one toggle, and zero if `sel` ends at its previous sampled value.

## Structure
- Shared package `mux_pkg`: default `WIDTH` and `CNT_W` constants, plus the `SEL_A`=0 and `SEL_B`=1 select encodings.
- One sub-module, `mux_sel_counter`: contains the `sel_q` register, the change detector and the saturating `toggle_cnt`.
- The top level holds the combinational select and the `out_q` register.

## Test plan
- Combinational select, no clock needed:
  - `a`=0, `b`=0, `sel`=0 → `out`=0.
  - After 10 ns: `a`=0, `b`=1, `sel`=0 → `out`=0.
  - After 10 ns: `a`=0, `b`=1, `sel`=1 → `out`=1.
- Reset: with `rst`=1 asynchronously (mid-cycle, counter nonzero) → `out_q`, `sel_q` and `toggle_cnt` all read 0 immediately, while `out` still follows `sel`.
- Registered path: with `WIDTH`=8, `a`=8'h3C, `b`=8'hA5, `sel` switching 0 → 1 → 0 on successive edges → `out_q` reads 3C, A5, 3C, each one cycle after `out`.
- Toggle counting: `sel` sequence 0,1,1,0,1 sampled on 5 edges after reset → `toggle_cnt`=3.
- Saturation: with `CNT_W`=2, toggle `sel` every cycle for 6 cycles → `toggle_cnt` reaches 3 and holds at 3.
